ysyx_22040759_mem_arbiter: RTL
==============================

// Module: ysyx_22040759_mem_arbiter
// PURPOSE
// Shares one downstream memory-access port (level read/write request, 1-cycle data_valid pulse) between the
// IF-stage fetch requester (read only) and the MEM-stage requester (read or write). Sits between the pipeline
// and the request splitter/AXI master. One transaction outstanding at a time; request fields registered at grant.
// MEM has priority by default; a starvation counter forces an IF grant after STARVE_MAX consecutive MEM wins.
// PARAMETERS
// ADDR_W      64  address width, all ports
// DATA_W      64  data width, all ports
// STARVE_MAX  4   consecutive MEM grants while IF waits before IF is forced (>=1)
// PORTS
// clock             in   1       system clock, all state on rising edge
// reset             in   1       synchronous, active-low reset
// if_addr_valid_i   in   1       IF read request; held until if_data_valid_o
// if_addr_i         in   ADDR_W  IF fetch address
// if_size_i         in   2       IF access size (0=B,1=H,2=W,3=D)
// if_data_valid_o   out  1       1-cycle pulse: IF read data valid
// if_rdata_o        out  DATA_W  IF read data, valid with if_data_valid_o
// mem_addr_valid_i  in   1       MEM request; held until mem_data_valid_o
// mem_wen_i         in   1       1=write, 0=read
// mem_addr_i        in   ADDR_W  MEM address
// mem_wdata_i       in   DATA_W  MEM write data
// mem_size_i        in   2       MEM access size
// mem_data_valid_o  out  1       1-cycle pulse: MEM read data valid / write done
// mem_rdata_o       out  DATA_W  MEM read data
// rd_addr_valid_o   out  1       downstream read request (level)
// rd_addr_o         out  ADDR_W  downstream read address
// rd_size_o         out  2       downstream read size
// rd_data_valid_i   in   1       downstream read completion pulse
// rd_data_i         in   DATA_W  downstream read data
// wr_addr_valid_o   out  1       downstream write request (level)
// wr_addr_o         out  ADDR_W  downstream write address
// wr_data_o         out  DATA_W  downstream write data
// wr_size_o         out  2       downstream write size
// wr_data_valid_i   in   1       downstream write completion pulse
// busy_o            out  1       1 whenever state != IDLE
// BEHAVIOUR
// - States: IDLE, IF_RD, MEM_RD, MEM_WR. Reset (reset==0 at edge): IDLE, starve_cnt=0, all *_valid_o=0,
//   busy_o=0, address/data/size registers 0. Reset mid-transaction abandons it; no completion forwarded.
// - IDLE arbitration (evaluated every IDLE cycle): if IF and MEM both valid: grant IF when
//   starve_cnt==STARVE_MAX, else MEM. Single valid requester wins. Neither -> stay IDLE.
// - On grant at edge N: capture addr/size(/wdata) of winner into registers; state -> IF_RD / MEM_RD / MEM_WR
//   (MEM_WR if mem_wen_i); matching rd_/wr_addr_valid_o high from cycle N+1, held stable until completion.
// - starve_cnt: +1 (saturating at STARVE_MAX) on a MEM grant while if_addr_valid_i=1; cleared on any IF grant
//   or on a MEM grant with IF idle.
// - Completion: in IF_RD, rd_data_valid_i -> if_data_valid_o=1 same cycle (combinational), if_rdata_o=rd_data_i;
//   MEM_RD same via mem_*; MEM_WR: wr_data_valid_i -> mem_data_valid_o=1, mem_rdata_o=0. Next state IDLE;
//   request valid drops the cycle after completion. Earliest re-grant: cycle after return to IDLE.
// - Completion pulses not matching the current state (incl. any in IDLE) are ignored, never forwarded.
// - Requester input changes while its transaction is in flight have no effect (fields registered).
// - Both *_data_valid_o are 0 outside the completion cycle; if_rdata_o/mem_rdata_o are 0 when not valid.
// - rd_addr_valid_o and wr_addr_valid_o never both 1.
// TESTING
// 1 Reset: hold reset=0 with both requesters valid, 3 cycles -> all valids 0, busy_o=0, no grant.
// 2 Lone IF read addr=0x8000_0000 size=3, downstream returns 0x1122334455667788 after 2 cycles
//   -> rd_addr_valid_o high from cycle 1, if_data_valid_o pulse with that data, back to IDLE.
// 3 Simultaneous IF read + MEM write addr=0x8000_1000 data=0xDEAD -> MEM_WR first, wr_* match, then IF_RD.
// 4 Starvation: IF held valid, MEM re-requests every IDLE, STARVE_MAX=4 -> 4 MEM grants, then IF granted 5th.
// 5 Stray rd_data_valid_i in IDLE and during MEM_WR -> no *_data_valid_o pulse, state unchanged.
// 6 reset asserted during MEM_RD, then rd_data_valid_i -> IDLE, no mem_data_valid_o, clean re-grant after release.

Source files
------------

// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// Bus bundle between the pipeline requesters, the arbiter and the downstream memory port.
// Signal suffixes are named from the arbiter's point of view.
//   if_*   : IF-stage fetch requester (read only)
//   mem_*  : MEM-stage requester (read or write)
//   rd_*   : downstream read channel (level request, 1-cycle completion pulse)
//   wr_*   : downstream write channel (level request, 1-cycle completion pulse)
// Modports: slave = arbiter side, master = pipeline/downstream (environment) side.
interface ysyx_22040759_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);
  logic              if_addr_valid_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [1:0]        if_size_i;
  logic              if_data_valid_o;
  logic [DATA_W-1:0] if_rdata_o;

  logic              mem_addr_valid_i;
  logic              mem_wen_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [1:0]        mem_size_i;
  logic              mem_data_valid_o;
  logic [DATA_W-1:0] mem_rdata_o;

  logic              rd_addr_valid_o;
  logic [ADDR_W-1:0] rd_addr_o;
  logic [1:0]        rd_size_o;
  logic              rd_data_valid_i;
  logic [DATA_W-1:0] rd_data_i;

  logic              wr_addr_valid_o;
  logic [ADDR_W-1:0] wr_addr_o;
  logic [DATA_W-1:0] wr_data_o;
  logic [1:0]        wr_size_o;
  logic              wr_data_valid_i;

  modport slave (
    input  if_addr_valid_i, if_addr_i, if_size_i,
    output if_data_valid_o, if_rdata_o,
    input  mem_addr_valid_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_size_i,
    output mem_data_valid_o, mem_rdata_o,
    output rd_addr_valid_o, rd_addr_o, rd_size_o,
    input  rd_data_valid_i, rd_data_i,
    output wr_addr_valid_o, wr_addr_o, wr_data_o, wr_size_o,
    input  wr_data_valid_i
  );

  modport master (
    output if_addr_valid_i, if_addr_i, if_size_i,
    input  if_data_valid_o, if_rdata_o,
    output mem_addr_valid_i, mem_wen_i, mem_addr_i, mem_wdata_i, mem_size_i,
    input  mem_data_valid_o, mem_rdata_o,
    input  rd_addr_valid_o, rd_addr_o, rd_size_o,
    output rd_data_valid_i, rd_data_i,
    input  wr_addr_valid_o, wr_addr_o, wr_data_o, wr_size_o,
    output wr_data_valid_i
  );
endinterface

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Shares one downstream memory port between the IF fetch requester and the MEM requester.
// One transaction in flight at a time; the winner's fields are registered at grant.
// MEM wins ties unless IF has lost STARVE_MAX consecutive contested grants.
// Ports:
//   clock   : system clock, all state on the rising edge
//   reset   : synchronous active-low reset
//   bus_io  : requester + downstream channels (slave modport)
//   busy_o  : high whenever a transaction is in flight
module ysyx_22040759_mem_arbiter #(
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                              clock,
  input  logic                              reset,
  ysyx_22040759_mem_arbiter_if.slave        bus_io,
  output logic                              busy_o
);

  localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {StIdle, StIfRd, StMemRd, StMemWr} state_e;

  state_e            state_q;
  logic [CntW-1:0]   starve_q;
  logic [CntW-1:0]   starve_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [1:0]        size_q;
  logic              rd_valid_q;
  logic              wr_valid_q;

  logic grant_if;
  logic grant_mem;
  logic starve_full;
  logic if_done;
  logic mem_rd_done;
  logic mem_wr_done;

  // Arbitration: IF only beats a concurrent MEM request once the starvation count is full.
  always_comb begin
    starve_full = (starve_q == CntW'(STARVE_MAX));
    grant_if    = bus_io.if_addr_valid_i & (~bus_io.mem_addr_valid_i | starve_full);
    grant_mem   = bus_io.mem_addr_valid_i & ~grant_if;
    starve_d    = '0;
    // Only a MEM win while IF is waiting counts towards starvation.
    if (grant_mem && bus_io.if_addr_valid_i) begin
      starve_d = starve_full ? starve_q : starve_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= StIdle;
      starve_q   <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      size_q     <= '0;
      rd_valid_q <= 1'b0;
      wr_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_if) begin
            state_q    <= StIfRd;
            addr_q     <= bus_io.if_addr_i;
            size_q     <= bus_io.if_size_i;
            rd_valid_q <= 1'b1;
            starve_q   <= '0;
          end else if (grant_mem) begin
            state_q    <= bus_io.mem_wen_i ? StMemWr : StMemRd;
            addr_q     <= bus_io.mem_addr_i;
            size_q     <= bus_io.mem_size_i;
            wdata_q    <= bus_io.mem_wdata_i;
            rd_valid_q <= ~bus_io.mem_wen_i;
            wr_valid_q <= bus_io.mem_wen_i;
            starve_q   <= starve_d;
          end
        end
        StIfRd, StMemRd: begin
          if (bus_io.rd_data_valid_i) begin
            state_q    <= StIdle;
            rd_valid_q <= 1'b0;
          end
        end
        StMemWr: begin
          if (bus_io.wr_data_valid_i) begin
            state_q    <= StIdle;
            wr_valid_q <= 1'b0;
          end
        end
      endcase
    end
  end

  // Completions are forwarded in the same cycle; pulses that do not match the state are dropped.
  always_comb begin
    if_done     = (state_q == StIfRd) & bus_io.rd_data_valid_i;
    mem_rd_done = (state_q == StMemRd) & bus_io.rd_data_valid_i;
    mem_wr_done = (state_q == StMemWr) & bus_io.wr_data_valid_i;
  end

  assign bus_io.if_data_valid_o  = if_done;
  assign bus_io.if_rdata_o       = if_done ? bus_io.rd_data_i : '0;
  assign bus_io.mem_data_valid_o = mem_rd_done | mem_wr_done;
  assign bus_io.mem_rdata_o      = mem_rd_done ? bus_io.rd_data_i : '0;

  assign bus_io.rd_addr_valid_o  = rd_valid_q;
  assign bus_io.rd_addr_o        = addr_q;
  assign bus_io.rd_size_o        = size_q;
  assign bus_io.wr_addr_valid_o  = wr_valid_q;
  assign bus_io.wr_addr_o        = addr_q;
  assign bus_io.wr_data_o        = wdata_q;
  assign bus_io.wr_size_o        = size_q;

  assign busy_o = (state_q != StIdle);

endmodule
